sar_scan_sequencer: RTL and testbench

- Sequences the 4-bit SAR logic block across up to NCH analog channels.
- Drives the analog mux select, the sample/hold strobe and the SAR synchronous reset.
- Waits for the SAR conv_done flag, captures the SAR result and presents it with its channel tag on a valid/ready result port.
- Sits between the SAR logic and the digital consumer (register bank or FIFO).

---
 rtl/sar_scan_sequencer_if.sv | 30 +++
 rtl/sar_scan_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_sar_scan_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_scan_sequencer_if.sv
// Result port of the SAR scan sequencer: captured code plus channel tag,
// delivered to the consumer (register bank or FIFO) with a valid/ready handshake.
//
// Handshake: the master raises res_valid together with stable res_data/res_ch
// and holds all three unchanged until a rising clk edge on which res_ready is
// also 1; that edge transfers the result. res_valid never drops without a
// transfer (except on reset), and res_ready may be driven freely by the slave.
interface sar_scan_sequencer_if #(
   parameter int BITS = 4,
   parameter int CHW  = 2
);
   logic [BITS-1:0] res_data;
   logic [CHW-1:0]  res_ch;
   logic            res_valid;
   logic            res_ready;

   modport master (
      output res_data,
      output res_ch,
      output res_valid,
      input  res_ready
   );

   modport slave (
      input  res_data,
      input  res_ch,
      input  res_valid,
      output res_ready
   );
endinterface

// File: rtl/sar_scan_sequencer.sv
// Walks the 4-bit SAR logic across the enabled analog channels in ascending
// order: selects the mux channel, strobes sample/hold, releases the SAR reset
// for conversion, waits for conv_done (bounded by a timeout), and hands each
// code plus its channel tag to the consumer. Every output is registered.
module sar_scan_sequencer #(
   parameter int NCH            = 4,
   parameter int BITS           = 4,
   parameter int SAMPLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 12,
   localparam int CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                cont,
   input  logic [NCH-1:0]      ch_mask,
   input  logic                sar_conv_done,
   input  logic [BITS-1:0]     sar_bitout,
   output logic                sar_rst,
   output logic                sample,
   output logic [CHW-1:0]      ch_sel,
   sar_scan_sequencer_if.master res,
   output logic                busy,
   output logic                scan_done,
   output logic                timeout_err,
   output logic [2:0]          state_dbg
);

   // One counter serves both the sample hold and the conversion timeout.
   localparam int CMAX = (TIMEOUT_CYCLES > SAMPLE_CYCLES) ? TIMEOUT_CYCLES : SAMPLE_CYCLES;
   localparam int CNTW = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SAMPLE  = 3'd1,
      S_CONVERT = 3'd2,
      S_OUTPUT  = 3'd3,
      S_NEXT    = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [NCH-1:0]    mask_q, mask_d;
   logic [CHW-1:0]    ch_sel_q, ch_sel_d;
   logic [BITS-1:0]   res_data_q, res_data_d;
   logic [CHW-1:0]    res_ch_q, res_ch_d;
   logic              res_valid_q, res_valid_d;
   logic              scan_done_q, scan_done_d;
   logic              timeout_q, timeout_d;
   logic              sar_rst_q, sar_rst_d;
   logic              sample_q, sample_d;
   logic              busy_q, busy_d;
   logic [CHW:0]      first_pick;
   logic [CHW:0]      next_pick;

   // Lowest set bit of m strictly above floor_idx; MSB of the result flags "found".
   function automatic logic [CHW:0] pick_bit(input logic [NCH-1:0] m, input int floor_idx);
      logic [CHW:0] r;
      r = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (m[i] && (i > floor_idx)) begin
            r = {1'b1, CHW'(i)};
         end
      end
      return r;
   endfunction

   // Next-state and next-output decode; outputs are registered from the *_d values.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mask_d      = mask_q;
      ch_sel_d    = ch_sel_q;
      res_data_d  = res_data_q;
      res_ch_d    = res_ch_q;
      res_valid_d = res_valid_q;
      scan_done_d = 1'b0;
      timeout_d   = timeout_q;
      first_pick  = pick_bit(ch_mask, -1);
      next_pick   = pick_bit(mask_q, int'(ch_sel_q));

      case (state_q)
         S_IDLE: begin
            // A start with an empty mask is ignored and leaves timeout_err alone.
            if (start && first_pick[CHW]) begin
               mask_d    = ch_mask;
               ch_sel_d  = first_pick[CHW-1:0];
               timeout_d = 1'b0;
               cnt_d     = '0;
               state_d   = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (cnt_q == CNTW'(SAMPLE_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_CONVERT;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_CONVERT: begin
            // conv_done wins over a timeout landing on the same cycle.
            if (sar_conv_done) begin
               res_data_d  = sar_bitout;
               res_ch_d    = ch_sel_q;
               res_valid_d = 1'b1;
               state_d     = S_OUTPUT;
            end else if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
               timeout_d = 1'b1;
               state_d   = S_NEXT;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_OUTPUT: begin
            if (res.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_NEXT;
            end
         end
         S_NEXT: begin
            cnt_d = '0;
            if (next_pick[CHW]) begin
               ch_sel_d = next_pick[CHW-1:0];
               state_d  = S_SAMPLE;
            end else begin
               scan_done_d = 1'b1;
               // Continuous mode re-reads the live mask so edits apply to the next scan.
               if (cont && first_pick[CHW]) begin
                  mask_d   = ch_mask;
                  ch_sel_d = first_pick[CHW-1:0];
                  state_d  = S_SAMPLE;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The SAR is held in reset everywhere except while it converts.
      sar_rst_d = (state_d != S_CONVERT);
      sample_d  = (state_d == S_SAMPLE);
      busy_d    = (state_d != S_IDLE);
   end

   // State and output registers; reset drops any pending result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mask_q      <= '0;
         ch_sel_q    <= '0;
         res_data_q  <= '0;
         res_ch_q    <= '0;
         res_valid_q <= 1'b0;
         scan_done_q <= 1'b0;
         timeout_q   <= 1'b0;
         sar_rst_q   <= 1'b1;
         sample_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mask_q      <= mask_d;
         ch_sel_q    <= ch_sel_d;
         res_data_q  <= res_data_d;
         res_ch_q    <= res_ch_d;
         res_valid_q <= res_valid_d;
         scan_done_q <= scan_done_d;
         timeout_q   <= timeout_d;
         sar_rst_q   <= sar_rst_d;
         sample_q    <= sample_d;
         busy_q      <= busy_d;
      end
   end

   assign sar_rst       = sar_rst_q;
   assign sample        = sample_q;
   assign ch_sel        = ch_sel_q;
   assign res.res_data  = res_data_q;
   assign res.res_ch    = res_ch_q;
   assign res.res_valid = res_valid_q;
   assign busy          = busy_q;
   assign scan_done     = scan_done_q;
   assign timeout_err   = timeout_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Bench for sar_scan_sequencer: behavioural SAR + consumer model on the
// falling edge, expected-result queue built from the channel mask, and one
// task per scenario.
module tb_sar_scan_sequencer;
   localparam int NCH            = 4;
   localparam int BITS           = 4;
   localparam int SAMPLE_CYCLES  = 2;
   localparam int TIMEOUT_CYCLES = 12;
   localparam int CHW            = 2;

   logic            clk;
   logic            reset;
   logic            start;
   logic            cont;
   logic [NCH-1:0]  ch_mask;
   logic            sar_conv_done;
   logic [BITS-1:0] sar_bitout;
   logic            sar_rst;
   logic            sample;
   logic [CHW-1:0]  ch_sel;
   logic            busy;
   logic            scan_done;
   logic            timeout_err;
   logic [2:0]      state_dbg;

   sar_scan_sequencer_if #(.BITS(BITS), .CHW(CHW)) res_if ();

   sar_scan_sequencer #(
      .NCH(NCH), .BITS(BITS), .SAMPLE_CYCLES(SAMPLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cont(cont), .ch_mask(ch_mask),
      .sar_conv_done(sar_conv_done), .sar_bitout(sar_bitout), .sar_rst(sar_rst),
      .sample(sample), .ch_sel(ch_sel), .res(res_if), .busy(busy),
      .scan_done(scan_done), .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // environment state
   logic [BITS-1:0]         sar_val [NCH];
   bit                      sar_never [NCH];
   int                      sar_lat;
   int                      sar_cnt;
   int                      ready_mode;
   logic [CHW+BITS-1:0]     exp_q [$];
   logic [CHW+BITS-1:0]     exp_item;
   int                      n_cmp;
   int                      n_err;
   int                      scan_done_cnt;
   int                      sample_run;
   int                      conv_run;
   int                      last_conv;

   // SAR model, consumer and result scoreboard, all acting on the falling edge
   always @(negedge clk) begin
      if (reset) begin
         sar_cnt       = 0;
         sar_conv_done = 1'b0;
         sample_run    = 0;
         conv_run      = 0;
      end else begin
         if (sar_rst) begin
            sar_cnt       = 0;
            sar_conv_done = 1'b0;
         end else begin
            sar_cnt++;
            if (!sar_never[ch_sel] && sar_cnt >= sar_lat) begin
               sar_conv_done = 1'b1;
               sar_bitout    = sar_val[ch_sel];
            end
         end
         case (ready_mode)
            0:       res_if.res_ready = 1'b1;
            1:       res_if.res_ready = 1'($urandom_range(0, 1));
            default: res_if.res_ready = 1'b0;
         endcase
         if (res_if.res_valid && res_if.res_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL result_unexpected: got ch=%0d data=%h, required no result",
                        res_if.res_ch, res_if.res_data);
            end else begin
               exp_item = exp_q.pop_front();
               if ({res_if.res_ch, res_if.res_data} !== exp_item) begin
                  n_err++;
                  $display("FAIL result_value: got ch=%0d data=%h, required ch=%0d data=%h",
                           res_if.res_ch, res_if.res_data, exp_item[CHW+BITS-1:BITS], exp_item[BITS-1:0]);
               end
            end
         end
         if (scan_done) scan_done_cnt++;
         if (sample) begin
            sample_run++;
         end else if (sample_run != 0) begin
            n_cmp++;
            if (sample_run != SAMPLE_CYCLES) begin
               n_err++;
               $display("FAIL sample_width: got %0d cycles, required %0d", sample_run, SAMPLE_CYCLES);
            end
            sample_run = 0;
         end
         if (!sar_rst) begin
            conv_run++;
         end else if (conv_run != 0) begin
            last_conv = conv_run;
            conv_run  = 0;
         end
      end
   end

   // driver tasks
   task automatic pulse_start(input logic [NCH-1:0] m, input logic c);
      @(negedge clk);
      ch_mask = m;
      cont    = c;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load_scan(input logic [NCH-1:0] m);
      logic [CHW-1:0] c;
      for (int i = 0; i < NCH; i++) begin
         if (m[i] && !sar_never[i]) begin
            c = CHW'(i);
            exp_q.push_back({c, sar_val[i]});
         end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   // scenarios
   task automatic test_reset();
      #1;
      n_cmp++;
      if ({sar_rst, sample, ch_sel, res_if.res_data, res_if.res_ch, res_if.res_valid,
           busy, scan_done, timeout_err} !== {1'b1, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_values: got rst=%b smp=%b sel=%0d d=%h ch=%0d v=%b busy=%b sd=%b to=%b, required 1 0 0 0 0 0 0 0 0",
                  sar_rst, sample, ch_sel, res_if.res_data, res_if.res_ch, res_if.res_valid, busy, scan_done, timeout_err);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, sar_rst, sample} !== 3'b010) begin
         n_err++;
         $display("FAIL idle_after_reset: got busy=%b rst=%b smp=%b, required 0 1 0", busy, sar_rst, sample);
      end
   endtask

   task automatic test_single();
      int sd0;
      bit ok;
      sd0 = scan_done_cnt;
      sar_val[2] = 4'hA;
      sar_lat = 4;
      load_scan(4'b0100);
      pulse_start(4'b0100, 1'b0);
      n_cmp++;
      if (sample !== 1'b1 || ch_sel !== 2'd2) begin
         n_err++;
         $display("FAIL single_select: got sample=%b ch_sel=%0d, required 1 2", sample, ch_sel);
      end
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL single_idle: got busy=%b, required 0", busy); end
      n_cmp++;
      if (scan_done_cnt - sd0 !== 1) begin
         n_err++;
         $display("FAIL single_scan_done: got %0d pulses, required 1", scan_done_cnt - sd0);
      end
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL single_pending: got %0d undelivered, required 0", exp_q.size());
      end
   endtask

   task automatic test_full_scan();
      int sd0;
      bit ok;
      sd0 = scan_done_cnt;
      sar_val[0] = 4'h3; sar_val[1] = 4'h7; sar_val[2] = 4'h5; sar_val[3] = 4'hC;
      sar_lat = 3;
      load_scan(4'b1011);
      pulse_start(4'b1011, 1'b0);
      repeat (5) @(negedge clk);
      // start while busy must be ignored, with no queued scan
      pulse_start(4'b1111, 1'b0);
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL full_idle: got busy=%b, required 0", busy); end
      n_cmp++;
      if (scan_done_cnt - sd0 !== 1) begin
         n_err++;
         $display("FAIL full_scan_done: got %0d pulses, required 1", scan_done_cnt - sd0);
      end
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL full_pending: got %0d undelivered, required 0", exp_q.size());
      end
   endtask

   task automatic test_back_pressure();
      bit ok;
      bit seen;
      for (int i = 0; i < NCH; i++) sar_val[i] = 4'($urandom_range(0, 15));
      sar_lat = 2;
      ready_mode = 2;
      load_scan(4'b0110);
      pulse_start(4'b0110, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (res_if.res_valid) begin seen = 1'b1; break; end
      end
      n_cmp++;
      if (!seen) begin n_err++; $display("FAIL bp_valid: got res_valid=0, required 1"); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({res_if.res_valid, res_if.res_ch, res_if.res_data, sar_rst, sample} !== {1'b1, exp_q[0], 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL bp_hold: got v=%b ch=%0d d=%h rst=%b smp=%b, required 1 ch=%0d d=%h 1 0",
                     res_if.res_valid, res_if.res_ch, res_if.res_data, sar_rst, sample,
                     exp_q[0][CHW+BITS-1:BITS], exp_q[0][BITS-1:0]);
         end
      end
      ready_mode = 0;
      wait_idle(ok);
      n_cmp++;
      if (!ok || exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL bp_resume: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
      end
   endtask

   task automatic test_timeout();
      int sd0;
      bit ok;
      bit seen;
      sd0 = scan_done_cnt;
      sar_never[0] = 1'b1;
      sar_val[2] = 4'($urandom_range(0, 15));
      sar_lat = 5;
      load_scan(4'b0101);
      pulse_start(4'b0101, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (timeout_err) begin seen = 1'b1; break; end
      end
      n_cmp++;
      if (!seen || res_if.res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL to_flag: got timeout_err=%b res_valid=%b, required 1 0", timeout_err, res_if.res_valid);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (last_conv !== TIMEOUT_CYCLES) begin
         n_err++;
         $display("FAIL to_length: got %0d convert cycles, required %0d", last_conv, TIMEOUT_CYCLES);
      end
      wait_idle(ok);
      n_cmp++;
      if (!ok || timeout_err !== 1'b1 || exp_q.size() !== 0 || scan_done_cnt - sd0 !== 1) begin
         n_err++;
         $display("FAIL to_scan_end: got busy=%b to=%b pending=%0d sd=%0d, required 0 1 0 1",
                  busy, timeout_err, exp_q.size(), scan_done_cnt - sd0);
      end
      sar_never[0] = 1'b0;
      pulse_start('0, 1'b0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL to_empty_start: got busy=%b to=%b, required 0 1", busy, timeout_err);
      end
      load_scan(4'b0001);
      pulse_start(4'b0001, 1'b0);
      n_cmp++;
      if (timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL to_clear: got timeout_err=%b, required 0", timeout_err);
      end
      wait_idle(ok);
      n_cmp++;
      if (!ok || exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL to_rescan: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
      end
   endtask

   task automatic test_continuous();
      int sd0;
      bit ok;
      sd0 = scan_done_cnt;
      sar_val[0] = 4'($urandom_range(0, 15));
      sar_val[1] = 4'($urandom_range(0, 15));
      sar_lat = 3;
      load_scan(4'b0001);
      load_scan(4'b0010);
      pulse_start(4'b0001, 1'b1);
      ch_mask = 4'b0010;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (scan_done_cnt != sd0) break;
      end
      cont = 1'b0;
      wait_idle(ok);
      n_cmp++;
      if (!ok || scan_done_cnt - sd0 !== 2 || exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL cont_scans: got busy=%b sd=%0d pending=%0d, required 0 2 0",
                  busy, scan_done_cnt - sd0, exp_q.size());
      end
      n_cmp++;
      if (ch_sel !== 2'd1) begin
         n_err++;
         $display("FAIL cont_last_ch: got ch_sel=%0d, required 1", ch_sel);
      end
   endtask

   task automatic test_random();
      logic [NCH-1:0] m;
      int sd0;
      bit ok;
      ready_mode = 1;
      for (int it = 0; it < 8; it++) begin
         sd0 = scan_done_cnt;
         m = NCH'($urandom_range(1, 15));
         for (int i = 0; i < NCH; i++) sar_val[i] = 4'($urandom_range(0, 15));
         sar_lat = $urandom_range(1, 8);
         load_scan(m);
         pulse_start(m, 1'b0);
         wait_idle(ok);
         n_cmp++;
         if (!ok || exp_q.size() !== 0 || scan_done_cnt - sd0 !== 1) begin
            n_err++;
            $display("FAIL rand_scan mask=%b: got busy=%b pending=%0d sd=%0d, required 0 0 1",
                     m, busy, exp_q.size(), scan_done_cnt - sd0);
         end
      end
      ready_mode = 0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      sar_lat = 9;
      sar_val[3] = 4'($urandom_range(0, 15));
      load_scan(4'b1000);
      pulse_start(4'b1000, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!sar_rst) begin seen = 1'b1; break; end
      end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (!seen || {sar_rst, sample, ch_sel, res_if.res_data, res_if.res_ch, res_if.res_valid,
                    busy, scan_done, timeout_err} !== {1'b1, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_mid: got conv=%b rst=%b smp=%b sel=%0d v=%b busy=%b, required conv=1 1 0 0 0 0",
                  seen, sar_rst, sample, ch_sel, res_if.res_valid, busy);
      end
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      pulse_start('0, 1'b0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, sample, sar_rst, res_if.res_valid} !== 4'b0010) begin
         n_err++;
         $display("FAIL reset_empty_start: got busy=%b smp=%b rst=%b v=%b, required 0 0 1 0",
                  busy, sample, sar_rst, res_if.res_valid);
      end
   endtask

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got no end of run, required completion");
      $fatal(1, "watchdog expired");
   end

   // main sequence
   initial begin
      n_cmp = 0; n_err = 0; scan_done_cnt = 0;
      sample_run = 0; conv_run = 0; last_conv = 0; sar_cnt = 0;
      reset = 1'b1; start = 1'b0; cont = 1'b0; ch_mask = '0;
      sar_conv_done = 1'b0; sar_bitout = '0; sar_lat = 3; ready_mode = 0;
      res_if.res_ready = 1'b1;
      for (int i = 0; i < NCH; i++) begin sar_val[i] = '0; sar_never[i] = 1'b0; end
      repeat (3) @(negedge clk);
      test_reset();
      test_single();
      test_full_scan();
      test_back_pressure();
      test_timeout();
      test_continuous();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
